// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_t    : operation select carried on the op port.
//   md_state_t : FSM state encoding, exported for debug visibility.
//   FUNC_*     : R-type func codes handled by this unit.
//   func_to_op : maps a func code onto md_op_t for the decode stage.
//   op_is_signed / op_is_div : operation classification helpers.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_t;

  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  function automatic md_op_t func_to_op(input logic [5:0] func);
    md_op_t op;
    op = MD_MULT;
    case (func)
      FUNC_MULT:  op = MD_MULT;
      FUNC_MULTU: op = MD_MULTU;
      FUNC_DIV:   op = MD_DIV;
      FUNC_DIVU:  op = MD_DIVU;
      default:    op = MD_MULT;
    endcase
    return op;
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: pipeline-control bundle for the multiply/divide unit.
//   start/op/a/b : issue request (master -> unit).
//   busy/done    : progress indication (unit -> master).
//   hi/lo        : architectural HI/LO registers (unit -> master).
//   state        : current FSM state, for debug observation.
//   wr_hi/wr_lo/wdata : MTHI/MTLO writes, present only with MDU_MTHILO_EN.
// Handshake: a request is taken at a rising clk edge where start=1 and the
// unit is not busy (IDLE or DONE); start during busy is dropped, never queued.
// done pulses for exactly one cycle, and hi/lo hold the result in that cycle.
interface mult_div_unit_if #(parameter int WIDTH = 32) ();
  import mdu_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_t        state;

`ifdef MDU_MTHILO_EN
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;

  modport master (output start, op, a, b, wr_hi, wr_lo, wdata,
                  input  busy, done, hi, lo, state);
  modport slave  (input  start, op, a, b, wr_hi, wr_lo, wdata,
                  output busy, done, hi, lo, state);
`else
  modport master (output start, op, a, b,
                  input  busy, done, hi, lo, state);
  modport slave  (input  start, op, a, b,
                  output busy, done, hi, lo, state);
`endif

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// md_sign_fix: combinational sign handling around the unsigned core.
//   a, b, op_signed        -> a_mag, b_mag : operand magnitudes at issue.
//   res_signed, a_neg, b_neg               : captured sign info of the op.
//   raw_prod/raw_quo/raw_rem -> prod/quo/rem : sign-corrected results.
// Product and quotient are negated when operand signs differ; the remainder
// follows the dividend's sign. Negation wraps modulo the result width.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op_signed,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  input  logic               res_signed,
  input  logic               a_neg,
  input  logic               b_neg,
  input  logic [2*WIDTH-1:0] raw_prod,
  input  logic [WIDTH-1:0]   raw_quo,
  input  logic [WIDTH-1:0]   raw_rem,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem
);

  logic flip;

  always_comb begin
    a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (op_signed && b[WIDTH-1]) ? -b : b;
    flip  = res_signed && (a_neg ^ b_neg);
    prod  = flip ? -raw_prod : raw_prod;
    quo   = flip ? -raw_quo : raw_quo;
    rem   = (res_signed && a_neg) ? -raw_rem : raw_rem;
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding HI/LO.
//   clk  : rising-edge clock.
//   rst  : asynchronous active-high reset.
//   bus  : mult_div_unit_if.slave (start/op/a/b in, busy/done/hi/lo/state out).
// One iteration per cycle for WIDTH cycles; start at edge T yields done in
// cycle T+WIDTH+1. HI/LO hold their old values until the last RUN edge.
// Optional feature macro MDU_MTHILO_EN adds MTHI/MTLO writes through
// bus.wr_hi/bus.wr_lo/bus.wdata, honoured only while not busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  mult_div_unit_if.slave  bus
);
  import mdu_pkg::*;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  md_op_t             op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q;
  logic               a_neg_q, b_neg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic               last_iter;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a_mag, in_b_mag;

  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign in_signed = op_is_signed(bus.op);
  assign accept    = bus.start && (state_q != ST_RUN);
  assign last_iter = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // One instance serves both ends: magnitudes come from the live operands
  // (used only on the accepting edge), corrections from captured signs.
  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .a          (bus.a),
    .b          (bus.b),
    .op_signed  (in_signed),
    .a_mag      (in_a_mag),
    .b_mag      (in_b_mag),
    .res_signed (op_is_signed(op_q)),
    .a_neg      (a_neg_q),
    .b_neg      (b_neg_q),
    .raw_prod   (acc_d),
    .raw_quo    (quo_d),
    .raw_rem    (rem_d),
    .prod       (prod_fix),
    .quo        (quo_fix),
    .rem        (rem_fix)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One iteration of both engines; only the one matching op_q is used.
  always_comb begin
    // Shift-add: multiplier sits in the low half and shifts out as the
    // partial product shifts in from the top.
    add_hi = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    acc_d  = {add_hi, acc_q[WIDTH-1:1]};

    // Restoring division: dividend bits shift out of quo_q into the
    // partial remainder, quotient bits shift in at the bottom. The extra
    // bit of rem_sh/diff makes the borrow visible as the sign.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_mag_q};
    q_bit  = ~diff[WIDTH];
    rem_d  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], q_bit};

    // Most-negative / -1 needs no special path: magnitudes give quotient
    // 2^(WIDTH-1), whose negation wraps to itself, and remainder 0.
    if (op_is_div(op_q)) begin
      if (b_mag_q == '0) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op;
        a_q     <= bus.a;
        a_mag_q <= in_a_mag;
        b_mag_q <= in_b_mag;
        a_neg_q <= in_signed && bus.a[WIDTH-1];
        b_neg_q <= in_signed && bus.b[WIDTH-1];
        acc_q   <= {{WIDTH{1'b0}}, in_b_mag};
        rem_q   <= '0;
        quo_q   <= in_a_mag;
        cnt_q   <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q <= acc_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= last_iter ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  // HI/LO: result on the last RUN edge; MTHI/MTLO only when not busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last_iter) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
`ifdef MDU_MTHILO_EN
    else if (state_q != ST_RUN) begin
      if (bus.wr_hi) hi_q <= bus.wdata;
      if (bus.wr_lo) lo_q <= bus.wdata;
    end
`endif
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state_q;

endmodule
